// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch stage; a slot ring sits between the PC stream and imem.
// Build option FETCH_MISALIGN_CHECK_EN: misaligned PCs skip memory and return a flagged NOP.
module fetch_unit #(
  parameter int width_p = 32,
  parameter int depth_p = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pc_valid_i,
  input  logic [width_p-1:0] pc_i,
  output logic               pc_ready_o,
  input  logic               flush_i,
  output logic               imem_req_o,
  output logic [width_p-1:0] imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [width_p-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [width_p-1:0] instr_o,
  output logic [width_p-1:0] instr_pc_o,
  output logic               instr_misaligned_o
);

  localparam int idx_w = $clog2(depth_p);
  localparam int ptr_w = idx_w + 1;
  localparam logic [ptr_w-1:0] ptr_one = ptr_w'(1);

  logic [ptr_w-1:0] alloc_reg, fill_reg, rd_reg, disc_reg;
  logic [ptr_w-1:0] unfilled, used;
  logic [ptr_w:0]   occupancy;
  logic             space, misaligned, accept;
  logic             rsp, rsp_drop, rsp_fill, pop, rvalid_owed;
  logic [idx_w-1:0] alloc_idx, rd_idx, fill_slot;

  logic [width_p-1:0] slot_pc    [depth_p];
  logic [width_p-1:0] slot_instr [depth_p];

  assign alloc_idx = alloc_reg[idx_w-1:0];
  assign rd_idx    = rd_reg[idx_w-1:0];

  // Flushed-but-owed responses still occupy memory capacity, so they count against space.
  assign used      = alloc_reg - rd_reg;
  assign occupancy = {1'b0, used} + {1'b0, disc_reg};
  assign space     = occupancy < (ptr_w + 1)'(depth_p);

  assign accept      = rst_ni & pc_valid_i & space & ~flush_i;
  assign imem_req_o  = accept & ~misaligned;
  assign pc_ready_o  = misaligned ? accept : (imem_req_o & imem_gnt_i);
  assign imem_addr_o = rst_ni ? {pc_i[width_p-1:2], 2'b00} : '0;

  assign rsp         = imem_rvalid_i & ~flush_i;
  assign rsp_drop    = rsp & (disc_reg != '0);
  assign rsp_fill    = rsp & (disc_reg == '0);
  assign pop         = instr_valid_o & instr_ready_i & ~flush_i;
  assign rvalid_owed = imem_rvalid_i & ((disc_reg != '0) | (unfilled != '0));

  assign instr_o    = slot_instr[rd_idx];
  assign instr_pc_o = slot_pc[rd_idx];

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [width_p-1:0] nop_instr = width_p'(32'h0000_0013);

  // Memory requests are a subsequence of the slots; mreq/fill count only those.
  logic [ptr_w-1:0] mreq_reg;
  logic             issue;
  logic             slot_done [depth_p];
  logic             slot_mis  [depth_p];
  logic [idx_w-1:0] req_slot  [depth_p];

  assign misaligned         = pc_i[1:0] != 2'b00;
  assign issue              = imem_req_o & imem_gnt_i;
  assign unfilled           = mreq_reg - fill_reg;
  assign fill_slot          = req_slot[fill_reg[idx_w-1:0]];
  assign instr_valid_o      = (used != '0) && slot_done[rd_idx];
  assign instr_misaligned_o = slot_mis[rd_idx];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mreq_reg <= '0;
    end else if (flush_i) begin
      mreq_reg <= '0;
    end else if (issue) begin
      mreq_reg <= mreq_reg + ptr_one;
    end
  end
`else
  assign misaligned         = 1'b0;
  assign unfilled           = alloc_reg - fill_reg;
  assign fill_slot          = fill_reg[idx_w-1:0];
  assign instr_valid_o      = (fill_reg - rd_reg) != '0;
  assign instr_misaligned_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      alloc_reg <= '0;
      fill_reg  <= '0;
      rd_reg    <= '0;
      disc_reg  <= '0;
    end else if (flush_i) begin
      // A response landing in the flush cycle is dropped and settles one owed slot.
      alloc_reg <= '0;
      fill_reg  <= '0;
      rd_reg    <= '0;
      disc_reg  <= disc_reg + unfilled - ptr_w'(rvalid_owed);
    end else begin
      if (pc_ready_o) alloc_reg <= alloc_reg + ptr_one;
      if (rsp_fill)   fill_reg  <= fill_reg + ptr_one;
      if (rsp_drop)   disc_reg  <= disc_reg - ptr_one;
      if (pop)        rd_reg    <= rd_reg + ptr_one;
    end
  end

  for (genvar gi = 0; gi < depth_p; gi++) begin : g_slot
    logic [width_p-1:0] pc_reg, instr_reg;
    logic               alloc_hit, fill_hit;

    assign alloc_hit = pc_ready_o && (alloc_idx == idx_w'(gi));
    assign fill_hit  = rsp_fill && (fill_slot == idx_w'(gi));

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        pc_reg    <= '0;
        instr_reg <= '0;
      end else begin
        if (alloc_hit) pc_reg <= pc_i;
        if (fill_hit) instr_reg <= imem_rdata_i;
`ifdef FETCH_MISALIGN_CHECK_EN
        else if (alloc_hit && misaligned) instr_reg <= nop_instr;
`endif
      end
    end

    assign slot_pc[gi]    = pc_reg;
    assign slot_instr[gi] = instr_reg;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic             done_reg, mis_reg;
    logic [idx_w-1:0] tag_reg;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        done_reg <= 1'b0;
        mis_reg  <= 1'b0;
        tag_reg  <= '0;
      end else begin
        if (alloc_hit) begin
          done_reg <= misaligned;
          mis_reg  <= misaligned;
        end else if (fill_hit) begin
          done_reg <= 1'b1;
        end
        // Entry gi of the request queue remembers which slot its response belongs to.
        if (issue && (mreq_reg[idx_w-1:0] == idx_w'(gi))) tag_reg <= alloc_idx;
      end
    end

    assign slot_done[gi] = done_reg;
    assign slot_mis[gi]  = mis_reg;
    assign req_slot[gi]  = tag_reg;
`endif
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, hand-written corner sequences and a randomized run against a queue model.
module tb_fetch_unit;
  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pc_valid = 1'b0;
  logic [W-1:0]  pc_in = '0;
  logic          pc_ready;
  logic          flush = 1'b0;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          gnt = 1'b0;
  logic          rvalid = 1'b0;
  logic [W-1:0]  rdata = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [W-1:0]  instr;
  logic [W-1:0]  instr_pc;
  logic          instr_mis;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.width_p(W), .depth_p(D)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pc_valid_i(pc_valid), .pc_i(pc_in), .pc_ready_o(pc_ready),
    .flush_i(flush),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc), .instr_misaligned_o(instr_mis)
  );

  // Memory contents: a bijective function of the word address.
  function automatic logic [31:0] mdat(input logic [31:0] a);
    return a ^ 32'hC3A5_0F00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are then checked before the rising edge.
  task automatic drive(input int pv, input logic [31:0] pc, input int g, input int rv,
                       input logic [31:0] rd, input int rdy, input int fl);
    @(negedge clk);
    pc_valid = (pv != 0); pc_in = pc; gnt = (g != 0);
    rvalid = (rv != 0); rdata = rd; instr_ready = (rdy != 0); flush = (fl != 0);
    #1;
  endtask

  task automatic idle();
    drive(0, 32'h0, 1, 0, 32'h0, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pc_valid = 1'b1; pc_in = 32'h44; gnt = 1'b1;
    rvalid = 1'b0; rdata = '0; instr_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    #1;
    chkb("rst pc_ready", pc_ready, 1'b0);
    chkb("rst imem_req", imem_req, 1'b0);
    chkb("rst instr_valid", instr_valid, 1'b0);
    chkb("rst misaligned", instr_mis, 1'b0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst instr", instr, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    rst_n = 1'b1; pc_valid = 1'b0;
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic        e_prdy;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input int pv, input logic [31:0] pc, input int g, input int rv,
                              input logic [31:0] rpc, input int rdy, input int e_req,
                              input int e_prdy, input int e_val, input logic [31:0] e_pc);
    vec_t v;
    v.pv = (pv != 0); v.pc = pc; v.gnt = (g != 0); v.rv = (rv != 0);
    v.rdata = (rv != 0) ? mdat(rpc) : 32'h0; v.rdy = (rdy != 0);
    v.e_req = (e_req != 0); v.e_prdy = (e_prdy != 0); v.e_val = (e_val != 0);
    v.e_pc = e_pc; v.e_instr = mdat(e_pc);
    return v;
  endfunction

  typedef struct { logic [31:0] pc; bit filled; } ent_t;
  typedef struct { logic [31:0] addr; int epoch; } mreq_t;

  task automatic run_random(input int cycles);
    ent_t        exp_q[$];
    mreq_t       mem_q[$];
    mreq_t       m;
    int          epoch;
    int          stale;
    logic [31:0] pc_next;
    logic        pv, g, rv, rdy, fl, space, e_req, e_val;
    logic [31:0] rd;
    epoch = 0;
    pc_next = 32'h1000;
    for (int c = 0; c < cycles; c++) begin
      pv  = ($urandom_range(0, 9) < 7);
      g   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 29) == 0);
      rv  = (mem_q.size() > 0) && ($urandom_range(0, 2) != 0);
      rd  = rv ? mdat(mem_q[0].addr) : $urandom;
      drive(int'(pv), pc_next, int'(g), int'(rv), rd, int'(rdy), int'(fl));

      stale = 0;
      foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
      space = (exp_q.size() + stale) < D;
      e_req = pv & space & ~fl;
      e_val = (exp_q.size() > 0) && exp_q[0].filled;
      chkb("rnd imem_req", imem_req, e_req);
      chkb("rnd pc_ready", pc_ready, e_req & g);
      chk("rnd imem_addr", imem_addr, pc_next);
      chkb("rnd outstanding<=depth", (mem_q.size() <= D), 1'b1);
      chkb("rnd instr_valid", instr_valid, e_val);
      if (e_val) begin
        chk("rnd instr_pc", instr_pc, exp_q[0].pc);
        chk("rnd instr", instr, mdat(exp_q[0].pc));
        chkb("rnd misaligned", instr_mis, 1'b0);
      end

      if (fl) begin
        exp_q.delete();
        epoch++;
        if (rv) m = mem_q.pop_front();
        pc_next += 32'h1000;
      end else begin
        if (rv) begin
          m = mem_q.pop_front();
          if (m.epoch == epoch) begin
            for (int i = 0; i < exp_q.size(); i++) begin
              if (!exp_q[i].filled) begin
                exp_q[i].filled = 1'b1;
                break;
              end
            end
          end
        end
        if (e_val && rdy) begin
          $display("rnd cycle %0d: pop pc=0x%08h instr=0x%08h", c, exp_q[0].pc, instr);
          void'(exp_q.pop_front());
        end
        if (e_req && g) begin
          exp_q.push_back('{pc: pc_next, filled: 1'b0});
          mem_q.push_back('{addr: pc_next, epoch: epoch});
          pc_next += 32'h4;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];

    // Streaming (k = 1, grant always), then backpressure on a 4-deep ring.
    vecs.push_back(mk(1, 'h00, 1, 0, 'h00, 1, 1, 1, 0, 'h00));
    vecs.push_back(mk(1, 'h04, 1, 1, 'h00, 1, 1, 1, 0, 'h00));
    vecs.push_back(mk(1, 'h08, 1, 1, 'h04, 1, 1, 1, 1, 'h00));
    vecs.push_back(mk(1, 'h0C, 1, 1, 'h08, 1, 1, 1, 1, 'h04));
    vecs.push_back(mk(0, 'h00, 1, 1, 'h0C, 1, 0, 0, 1, 'h08));
    vecs.push_back(mk(0, 'h00, 1, 0, 'h00, 1, 0, 0, 1, 'h0C));
    vecs.push_back(mk(0, 'h00, 1, 0, 'h00, 1, 0, 0, 0, 'h00));
    vecs.push_back(mk(1, 'h10, 1, 0, 'h00, 0, 1, 1, 0, 'h00));
    vecs.push_back(mk(1, 'h14, 1, 1, 'h10, 0, 1, 1, 0, 'h00));
    vecs.push_back(mk(1, 'h18, 1, 1, 'h14, 0, 1, 1, 1, 'h10));
    vecs.push_back(mk(1, 'h1C, 1, 1, 'h18, 0, 1, 1, 1, 'h10));
    vecs.push_back(mk(1, 'h20, 1, 1, 'h1C, 0, 0, 0, 1, 'h10));
    vecs.push_back(mk(1, 'h20, 1, 0, 'h00, 0, 0, 0, 1, 'h10));
    vecs.push_back(mk(1, 'h20, 1, 0, 'h00, 1, 0, 0, 1, 'h10));
    vecs.push_back(mk(1, 'h20, 1, 0, 'h00, 1, 1, 1, 1, 'h14));
    vecs.push_back(mk(0, 'h00, 1, 1, 'h20, 1, 0, 0, 1, 'h18));
    vecs.push_back(mk(0, 'h00, 1, 0, 'h00, 1, 0, 0, 1, 'h1C));
    vecs.push_back(mk(0, 'h00, 1, 0, 'h00, 1, 0, 0, 1, 'h20));
    vecs.push_back(mk(0, 'h00, 1, 0, 'h00, 1, 0, 0, 0, 'h00));

    do_reset();
    foreach (vecs[i]) begin
      drive(int'(vecs[i].pv), vecs[i].pc, int'(vecs[i].gnt), int'(vecs[i].rv),
            vecs[i].rdata, int'(vecs[i].rdy), 0);
      $display("vec %0d: pc=0x%08h req=%b rdy=%b valid=%b ipc=0x%08h", i, vecs[i].pc,
               imem_req, pc_ready, instr_valid, instr_pc);
      chkb($sformatf("vec%0d imem_req", i), imem_req, vecs[i].e_req);
      chkb($sformatf("vec%0d pc_ready", i), pc_ready, vecs[i].e_prdy);
      chkb($sformatf("vec%0d instr_valid", i), instr_valid, vecs[i].e_val);
      if (vecs[i].e_val) begin
        chk($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
      end
    end

    $display("seq: flush with three requests in flight");
    do_reset();
    drive(1, 32'h40, 1, 0, 32'h0, 1, 0); chkb("fl0 req", imem_req, 1'b1);
    drive(1, 32'h44, 1, 0, 32'h0, 1, 0); chkb("fl1 req", imem_req, 1'b1);
    drive(1, 32'h48, 1, 0, 32'h0, 1, 0); chkb("fl2 req", imem_req, 1'b1);
    drive(1, 32'h100, 1, 0, 32'h0, 1, 1);
    chkb("fl flush-cycle req", imem_req, 1'b0);
    chkb("fl flush-cycle pc_ready", pc_ready, 1'b0);
    drive(1, 32'h100, 1, 1, mdat(32'h40), 1, 0);
    chkb("fl F+1 req", imem_req, 1'b1);
    chkb("fl F+1 pc_ready", pc_ready, 1'b1);
    chkb("fl F+1 valid", instr_valid, 1'b0);
    drive(0, 32'h0, 1, 1, mdat(32'h44), 1, 0); chkb("fl drop2 valid", instr_valid, 1'b0);
    drive(0, 32'h0, 1, 1, mdat(32'h48), 1, 0); chkb("fl drop3 valid", instr_valid, 1'b0);
    drive(0, 32'h0, 1, 1, mdat(32'h100), 1, 0); chkb("fl fill valid", instr_valid, 1'b0);
    idle();
    chkb("fl out valid", instr_valid, 1'b1);
    chk("fl out pc", instr_pc, 32'h100);
    chk("fl out instr", instr, mdat(32'h100));
    idle(); chkb("fl empty", instr_valid, 1'b0);

    $display("seq: flush coinciding with rvalid and pop");
    do_reset();
    drive(1, 32'h200, 1, 0, 32'h0, 0, 0);
    drive(1, 32'h204, 1, 1, mdat(32'h200), 0, 0);
    drive(1, 32'h208, 1, 0, 32'h0, 0, 0);
    chkb("fc pre valid", instr_valid, 1'b1);
    drive(1, 32'h300, 1, 1, mdat(32'h204), 1, 1);
    chkb("fc flush req", imem_req, 1'b0);
    drive(1, 32'h300, 1, 0, 32'h0, 1, 0);
    chkb("fc F+1 valid", instr_valid, 1'b0);
    chkb("fc iss0 req", imem_req, 1'b1);
    drive(1, 32'h304, 1, 0, 32'h0, 1, 0); chkb("fc iss1 req", imem_req, 1'b1);
    drive(1, 32'h308, 1, 0, 32'h0, 1, 0); chkb("fc iss2 req", imem_req, 1'b1);
    drive(1, 32'h30C, 1, 1, mdat(32'h208), 1, 0);
    chkb("fc owed-one blocks req", imem_req, 1'b0);
    chkb("fc stale valid", instr_valid, 1'b0);
    drive(1, 32'h30C, 1, 1, mdat(32'h300), 1, 0);
    chkb("fc iss3 req", imem_req, 1'b1);
    chkb("fc iss3 valid", instr_valid, 1'b0);
    drive(0, 32'h0, 1, 1, mdat(32'h304), 1, 0);
    chkb("fc out0 valid", instr_valid, 1'b1); chk("fc out0 pc", instr_pc, 32'h300);
    chk("fc out0 instr", instr, mdat(32'h300));
    drive(0, 32'h0, 1, 1, mdat(32'h308), 1, 0); chk("fc out1 pc", instr_pc, 32'h304);
    drive(0, 32'h0, 1, 1, mdat(32'h30C), 1, 0); chk("fc out2 pc", instr_pc, 32'h308);
    idle(); chk("fc out3 pc", instr_pc, 32'h30C); chk("fc out3 instr", instr, mdat(32'h30C));
    idle(); chkb("fc empty", instr_valid, 1'b0);

    $display("seq: grant stall");
    do_reset();
    drive(1, 32'h400, 0, 0, 32'h0, 1, 0);
    chkb("gs0 req", imem_req, 1'b1); chkb("gs0 pc_ready", pc_ready, 1'b0);
    chk("gs0 addr", imem_addr, 32'h400);
    drive(1, 32'h404, 0, 0, 32'h0, 1, 0);
    chkb("gs1 pc_ready", pc_ready, 1'b0); chk("gs1 addr", imem_addr, 32'h404);
    drive(1, 32'h408, 0, 0, 32'h0, 1, 0);
    chkb("gs2 pc_ready", pc_ready, 1'b0); chk("gs2 addr", imem_addr, 32'h408);
    drive(1, 32'h408, 1, 0, 32'h0, 1, 0); chkb("gs3 pc_ready", pc_ready, 1'b1);
    drive(0, 32'h0, 1, 1, mdat(32'h408), 1, 0); chkb("gs rsp valid", instr_valid, 1'b0);
    idle(); chkb("gs out valid", instr_valid, 1'b1); chk("gs out pc", instr_pc, 32'h408);

    $display("seq: misaligned pc behind an aligned fetch");
    do_reset();
    drive(1, 32'h500, 1, 0, 32'h0, 1, 0);
    drive(1, 32'h6, 1, 0, 32'h0, 1, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chkb("mis req", imem_req, 1'b0);
    chkb("mis pc_ready", pc_ready, 1'b1);
    drive(0, 32'h0, 1, 1, mdat(32'h500), 1, 0);
    chkb("mis order valid", instr_valid, 1'b0);
    idle();
    chk("mis first pc", instr_pc, 32'h500);
    chkb("mis first flag", instr_mis, 1'b0);
    idle();
    chkb("mis valid", instr_valid, 1'b1);
    chk("mis pc", instr_pc, 32'h6);
    chk("mis instr", instr, 32'h0000_0013);
    chkb("mis flag", instr_mis, 1'b1);
`else
    chkb("mis req", imem_req, 1'b1);
    chk("mis addr", imem_addr, 32'h4);
    chkb("mis pc_ready", pc_ready, 1'b1);
    drive(0, 32'h0, 1, 1, mdat(32'h500), 1, 0);
    chkb("mis order valid", instr_valid, 1'b0);
    drive(0, 32'h0, 1, 1, mdat(32'h4), 1, 0);
    chk("mis first pc", instr_pc, 32'h500);
    chkb("mis first flag", instr_mis, 1'b0);
    idle();
    chkb("mis valid", instr_valid, 1'b1);
    chk("mis pc", instr_pc, 32'h6);
    chk("mis instr", instr, mdat(32'h4));
    chkb("mis flag", instr_mis, 1'b0);
`endif
    idle(); chkb("mis empty", instr_valid, 1'b0);

    $display("seq: randomized run");
    do_reset();
    run_random(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
